// File: rtl/datapath_pkg.sv
// Shared encodings, pipeline payload types and the ALU for the RV32I ALU/LUI datapath.
package datapath_pkg;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;

  localparam logic [2:0] F3AddSub = 3'd0;
  localparam logic [2:0] F3Sll    = 3'd1;
  localparam logic [2:0] F3Slt    = 3'd2;
  localparam logic [2:0] F3Sltu   = 3'd3;
  localparam logic [2:0] F3Xor    = 3'd4;
  localparam logic [2:0] F3Sr     = 3'd5;
  localparam logic [2:0] F3Or     = 3'd6;
  localparam logic [2:0] F3And    = 3'd7;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  localparam logic [31:0] NopInstr = 32'h0000_0013;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluLui
  } alu_op_t;

  // All-zero value is a harmless "add x0,x0,0" with no write.
  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    alu_op_t     op;
    logic        use_imm;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } id_ex_t;

  function automatic alu_op_t f3_to_op(logic [2:0] f3, logic alt);
    alu_op_t op;
    case (f3)
      F3AddSub: op = alt ? AluSub : AluAdd;
      F3Sll:    op = AluSll;
      F3Slt:    op = AluSlt;
      F3Sltu:   op = AluSltu;
      F3Xor:    op = AluXor;
      F3Sr:     op = alt ? AluSra : AluSrl;
      F3Or:     op = AluOr;
      default:  op = AluAnd;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] alu(alu_op_t op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    case (op)
      AluAdd:  r = a + b;
      AluSub:  r = a - b;
      AluSll:  r = a << b[4:0];
      AluSlt:  r = {31'b0, $signed(a) < $signed(b)};
      AluSltu: r = {31'b0, a < b};
      AluXor:  r = a ^ b;
      AluSrl:  r = a >> b[4:0];
      AluSra:  r = $unsigned($signed(a) >>> b[4:0]);
      AluOr:   r = a | b;
      AluAnd:  r = a & b;
      AluLui:  r = b;
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_datapath_if.sv
// Write-back bus from the EX/WB register into the decode stage and register file.
interface cpu_datapath_if;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] data;

  modport master (output we, rd, data);
  modport slave  (input we, rd, data);
endinterface

// File: rtl/decode_stage.sv
// ID stage: decodes the ALU/LUI subset and reads operands; illegal encodings become NOPs.
module decode_stage
  import datapath_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   instr_i,
  cpu_datapath_if.slave wb_if,
  output id_ex_t        dec_o
);

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        valid, alt;
  logic [4:0]  rs1, rs2;
  logic [31:0] rdata1, rdata2;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    valid = 1'b0;
    alt   = 1'b0;
    rs1   = instr_i[19:15];
    rs2   = instr_i[24:20];
    case (opcode)
      OpcOp: begin
        alt   = (funct7 == F7Alt);
        valid = (funct7 == F7Base) || (alt && (funct3 == F3AddSub || funct3 == F3Sr));
      end
      OpcOpImm: begin
        rs2 = '0;
        // Upper immediate bits only select SRAI; for ADDI etc. they are plain immediate.
        alt = (funct3 == F3Sr) && (funct7 == F7Alt);
        if (funct3 == F3Sll)     valid = (funct7 == F7Base);
        else if (funct3 == F3Sr) valid = (funct7 == F7Base) || alt;
        else                     valid = 1'b1;
      end
      OpcLui: begin
        valid = 1'b1;
        rs1   = '0;
        rs2   = '0;
      end
      default: ;
    endcase
  end

  regfile rf (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2),
    .wb_if    (wb_if)
  );

  always_comb begin
    dec_o = '0;
    if (valid) begin
      dec_o.rd      = instr_i[11:7];
      dec_o.we      = (instr_i[11:7] != 5'd0);
      dec_o.rs1     = rs1;
      dec_o.rs2     = rs2;
      dec_o.rs1_val = rdata1;
      dec_o.rs2_val = rdata2;
      dec_o.op      = (opcode == OpcLui) ? AluLui : f3_to_op(funct3, alt);
      dec_o.use_imm = (opcode != OpcOp);
      dec_o.imm     = (opcode == OpcLui) ? {instr_i[31:12], 12'h000}
                                         : {{20{instr_i[31]}}, instr_i[31:20]};
    end
  end

endmodule

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports with write-first bypass, one write port.
module regfile (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    raddr1_i,
  input  logic [4:0]    raddr2_i,
  output logic [31:0]   rdata1_o,
  output logic [31:0]   rdata2_o,
  cpu_datapath_if.slave wb_if
);

  logic [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_if.we && wb_if.rd != 5'd0) begin
      regs[wb_if.rd] <= wb_if.data;
    end
  end

  // The value being written on this edge is returned, so ID never sees stale data.
  always_comb begin
    rdata1_o = regs[raddr1_i];
    if (raddr1_i == 5'd0) rdata1_o = '0;
    else if (wb_if.we && wb_if.rd == raddr1_i) rdata1_o = wb_if.data;
    rdata2_o = regs[raddr2_i];
    if (raddr2_i == 5'd0) rdata2_o = '0;
    else if (wb_if.we && wb_if.rd == raddr2_i) rdata2_o = wb_if.data;
  end

endmodule

// File: rtl/cpu_datapath.sv
// 4-stage IF/ID/EX/WB RV32I ALU/LUI datapath with internal ROM and full forwarding.
module cpu_datapath
  import datapath_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter string       IMEM_FILE  = "program.hex"
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] out
);

  localparam int unsigned AddrW = $clog2(IMEM_DEPTH);

  logic [31:0] imem [IMEM_DEPTH] = '{default: NopInstr};

  // Word index; the byte PC is {pc_q, 2'b00}, so the wrap is implicit.
  logic [AddrW-1:0] pc_q, pc_d;
  logic [31:0]      ifid_q, ifid_d;
  id_ex_t           id_dec, idex_q;
  logic             exwb_we_q, exwb_we_d;
  logic [4:0]       exwb_rd_q, exwb_rd_d;
  logic [31:0]      exwb_res_q, exwb_res_d;
  logic [31:0]      op_a, op_b;

  cpu_datapath_if wb_bus ();

  assign wb_bus.we   = exwb_we_q;
  assign wb_bus.rd   = exwb_rd_q;
  assign wb_bus.data = exwb_res_q;

  decode_stage decode (
    .clk     (clk),
    .rst     (rst),
    .instr_i (ifid_q),
    .wb_if   (wb_bus),
    .dec_o   (id_dec)
  );

  always_comb begin
    pc_d   = pc_q + 1'b1;
    ifid_d = imem[pc_q];
    op_a   = idex_q.rs1_val;
    op_b   = idex_q.rs2_val;
    if (exwb_we_q && exwb_rd_q == idex_q.rs1 && idex_q.rs1 != 5'd0) op_a = exwb_res_q;
    if (exwb_we_q && exwb_rd_q == idex_q.rs2 && idex_q.rs2 != 5'd0) op_b = exwb_res_q;
    exwb_we_d  = idex_q.we;
    exwb_rd_d  = idex_q.rd;
    exwb_res_d = alu(idex_q.op, op_a, idex_q.use_imm ? idex_q.imm : op_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      ifid_q     <= NopInstr;
      idex_q     <= '0;
      exwb_we_q  <= 1'b0;
      exwb_rd_q  <= '0;
      exwb_res_q <= '0;
    end else begin
      pc_q       <= pc_d;
      ifid_q     <= ifid_d;
      idex_q     <= id_dec;
      exwb_we_q  <= exwb_we_d;
      exwb_rd_q  <= exwb_rd_d;
      exwb_res_q <= exwb_res_d;
    end
  end

  assign out = exwb_res_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: directed programs plus random programs against an ISA-level model.
module tb_cpu_datapath;

  localparam int unsigned Depth = 256;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] out;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] prog [$];
  logic [31:0] mregs [32];
  logic        m_chk_out;
  logic [31:0] m_out;

  cpu_datapath #(.IMEM_DEPTH(Depth), .IMEM_FILE("program.hex")) dut (
    .clk (clk),
    .rst (rst),
    .out (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [2:0] f3, int rd, int rs1, int rs2);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(logic [2:0] f3, int rd, int rs1, int imm);
    return {12'(imm), 5'(rs1), f3, 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] enc_lui(int rd, logic [19:0] imm);
    return {imm, 5'(rd), 7'h37};
  endfunction

  function automatic logic [31:0] fetch(int k);
    int a = k % Depth;
    return (a < prog.size()) ? prog[a] : Nop;
  endfunction

  // Architectural meaning of one instruction against the model register state.
  function automatic void isa_eval(input logic [31:0] ins, output logic ok,
                                   output logic [4:0] rd, output logic [31:0] val);
    logic [31:0] a, b;
    logic [9:0]  fn;
    a   = mregs[ins[19:15]];
    b   = mregs[ins[24:20]];
    rd  = ins[11:7];
    ok  = 1'b1;
    val = '0;
    fn  = {ins[31:25], ins[14:12]};
    if (ins[6:0] == 7'h37) begin
      val = {ins[31:12], 12'h000};
    end else if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
      if (ins[6:0] == 7'h13) begin
        b = {{20{ins[31]}}, ins[31:20]};
        if (ins[14:12] != 3'd1 && ins[14:12] != 3'd5) fn[9:3] = 7'h00;
      end
      case (fn)
        {7'h00, 3'd0}: val = a + b;
        {7'h20, 3'd0}: val = a - b;
        {7'h00, 3'd1}: val = a << b[4:0];
        {7'h00, 3'd2}: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        {7'h00, 3'd3}: val = (a < b) ? 32'd1 : 32'd0;
        {7'h00, 3'd4}: val = a ^ b;
        {7'h00, 3'd5}: val = a >> b[4:0];
        {7'h20, 3'd5}: val = $signed(a) >>> b[4:0];
        {7'h00, 3'd6}: val = a | b;
        {7'h00, 3'd7}: val = a & b;
        default:       ok = 1'b0;
      endcase
    end else begin
      ok = 1'b0;
    end
  endfunction

  // Instruction k retires on edge k+4 and sits on out after edge k+3.
  task automatic model_at(input int edges);
    logic        ok;
    logic [4:0]  rd;
    logic [31:0] val;
    foreach (mregs[i]) mregs[i] = '0;
    m_chk_out = 1'b1;
    m_out     = '0;
    for (int k = 0; k <= edges - 4; k++) begin
      isa_eval(fetch(k), ok, rd, val);
      if (ok && rd != 5'd0) mregs[rd] = val;
    end
    if (edges >= 3) begin
      isa_eval(fetch(edges - 3), ok, rd, val);
      m_chk_out = ok && (rd != 5'd0);
      m_out     = val;
    end
  endtask

  task automatic load();
    for (int i = 0; i < Depth; i++) dut.imem[i] = fetch(i);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s x%0d", tag, i), dut.decode.rf.regs[i], mregs[i]);
  endtask

  task automatic reset_seq(input string tag);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_at(0);
    chk({tag, " out"}, out, 32'h0);
    chk({tag, " pc"}, 32'(dut.pc_q), 32'h0);
    check_all(tag);
  endtask

  task automatic run(input string tag, input int edges);
    rst = 1'b0;
    for (int e = 1; e <= edges; e++) begin
      @(negedge clk);
      model_at(e);
      if (m_chk_out) chk($sformatf("%s out@%0d", tag, e), out, m_out);
    end
    check_all(tag);
  endtask

  task automatic load_chain();
    prog.delete();
    prog.push_back(enc_i(3'd0, 1, 0, 5));
    prog.push_back(enc_i(3'd0, 2, 0, -3));
    prog.push_back(enc_r(7'h00, 3'd0, 3, 1, 2));
    prog.push_back(enc_r(7'h20, 3'd0, 4, 1, 2));
    prog.push_back(enc_r(7'h00, 3'd2, 5, 2, 1));
    prog.push_back(enc_lui(6, 20'h12345));
    load();
  endtask

  task automatic chain_expect(input string tag);
    chk({tag, " x1"}, dut.decode.rf.regs[1], 32'd5);
    chk({tag, " x2"}, dut.decode.rf.regs[2], 32'hFFFF_FFFD);
    chk({tag, " x3"}, dut.decode.rf.regs[3], 32'd2);
    chk({tag, " x4"}, dut.decode.rf.regs[4], 32'd8);
    chk({tag, " x5"}, dut.decode.rf.regs[5], 32'd1);
    chk({tag, " x6"}, dut.decode.rf.regs[6], 32'h1234_5000);
  endtask

  function automatic logic [31:0] rand_instr();
    int          rd  = $urandom_range(0, 7);
    int          rs1 = $urandom_range(0, 7);
    int          rs2 = $urandom_range(0, 7);
    logic [2:0]  f3  = 3'($urandom_range(0, 7));
    logic [11:0] imm = 12'($urandom);
    case ($urandom_range(0, 9))
      0, 1, 2, 3:
        return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                     f3, rd, rs1, rs2);
      4, 5, 6: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        else if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return enc_i(f3, rd, rs1, int'(imm));
      end
      7:       return enc_lui(rd, 20'($urandom));
      8:       return enc_r(7'h01, f3, rd, rs1, rs2);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    prog.delete();
    load();
    reset_seq("reset");

    load_chain();
    reset_seq("chain_rst");
    run("chain", 9);
    chain_expect("chain");

    prog.delete();
    prog.push_back(enc_i(3'd0, 1, 0, -16));
    prog.push_back(enc_i(3'd5, 2, 1, 'h402));
    prog.push_back(enc_i(3'd5, 3, 1, 28));
    prog.push_back(enc_i(3'd1, 4, 1, 1));
    load();
    reset_seq("shift_rst");
    run("shift", 7);
    chk("shift x2", dut.decode.rf.regs[2], 32'hFFFF_FFFC);
    chk("shift x3", dut.decode.rf.regs[3], 32'd15);
    chk("shift x4", dut.decode.rf.regs[4], 32'hFFFF_FFE0);

    prog.delete();
    prog.push_back(enc_i(3'd0, 31, 0, 9));
    prog.push_back(enc_i(3'd0, 0, 0, 7));
    prog.push_back(enc_r(7'h00, 3'd0, 1, 0, 0));
    prog.push_back(32'hFFFF_FFFF);
    load();
    reset_seq("x0_rst");
    run("x0", 7);
    chk("x0 x0", dut.decode.rf.regs[0], 32'h0);
    chk("x0 x1", dut.decode.rf.regs[1], 32'h0);
    chk("x0 x31", dut.decode.rf.regs[31], 32'd9);

    prog.delete();
    prog.push_back(enc_lui(1, 20'h80000));
    prog.push_back(enc_i(3'd0, 2, 1, -1));
    prog.push_back(enc_r(7'h00, 3'd3, 3, 2, 1));
    load();
    reset_seq("ovf_rst");
    run("ovf", 6);
    chk("ovf x1", dut.decode.rf.regs[1], 32'h8000_0000);
    chk("ovf x2", dut.decode.rf.regs[2], 32'h7FFF_FFFF);
    chk("ovf x3", dut.decode.rf.regs[3], 32'd1);

    load_chain();
    reset_seq("mid_rst0");
    run("mid_pre", 6);
    reset_seq("mid_rst");
    run("mid_post", 9);
    chain_expect("mid_post");

    for (int r = 0; r < 4; r++) begin
      prog.delete();
      for (int i = 0; i < 48; i++) prog.push_back(rand_instr());
      load();
      reset_seq($sformatf("rnd%0d_rst", r));
      run($sformatf("rnd%0d", r), 52);
    end

    prog.delete();
    prog.push_back(enc_i(3'd0, 1, 1, 1));
    load();
    reset_seq("wrap_rst");
    run("wrap", 262);
    chk("wrap x1", dut.decode.rf.regs[1], 32'd2);
    chk("wrap pc", 32'(dut.pc_q), 32'(262 % Depth));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
